divf_share_arbiter: RTL and testbench
=====================================

Name: divf_share_arbiter

Overview:
- Shares one elastic, in-order pipelined floating-point divider (divf, 8-stage delay buffer plus oehb) among NUM_REQ requesters.
- Round-robin arbitration selects one operand pair per cycle and issues it to the divider.
- The requester ID of each issued operation is recorded in a tag FIFO; each divider result is routed back to the requester at the FIFO head.
- Sits between several divf operation sites in a dataflow circuit and a single divf instance, saving area.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- NUM_REQ, 2, number of requesters (≥2).
- ID_WIDTH, 1, requester-index width; must satisfy 2^ID_WIDTH ≥ NUM_REQ.
- MAX_OUTSTANDING, 10, tag FIFO depth = max issued-but-unreturned ops; must be ≥ divider latency + 2 for full throughput.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_lhs  in  NUM_REQ*DATA_WIDTH  requester lhs operands, requester i at slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_rhs  in  NUM_REQ*DATA_WIDTH  requester rhs operands, same packing.
- req_valid  in  NUM_REQ  per-requester operand-pair valid.
- req_ready  out  NUM_REQ  per-requester operand-pair ready.
- res_data  out  NUM_REQ*DATA_WIDTH  per-requester result; every slice carries unit_result.
- res_valid  out  NUM_REQ  per-requester result valid.
- res_ready  in  NUM_REQ  per-requester result ready.
- unit_lhs  out  DATA_WIDTH  lhs to the shared divider.
- unit_rhs  out  DATA_WIDTH  rhs to the shared divider.
- unit_valid  out  1  operand valid to divider; one signal covers both lhs_valid and rhs_valid.
- unit_ready  in  1  divider input ready (AND of lhs_ready and rhs_ready).
- unit_result  in  DATA_WIDTH  divider result.
- unit_result_valid  in  1  divider result valid.
- unit_result_ready  out  1  divider result ready.

Behaviour:
- Reset (async, immediate):
  - rr_ptr=0, FIFO wr_ptr=rd_ptr=count=0.
  - Forced low: req_ready, res_valid, unit_valid, unit_result_ready.
  - The divider must share rst; in-flight ops are discarded on reset, including reset asserted mid-operation.
- Arbitration (combinational):
  - grant = first index j ≥ rr_ptr (mod NUM_REQ, searching upward) with req_valid[j]=1.
  - can_issue = (count < MAX_OUTSTANDING).
  - unit_valid = any(req_valid) & can_issue.
  - unit_lhs/unit_rhs = operands of grant; when no request is valid, drive requester 0's operands.
  - req_ready[grant] = can_issue & unit_ready; all other req_ready = 0.
  - No combinational path from unit_ready to unit_valid.
- Issue fire = unit_valid & unit_ready:
  - Push grant ID into the tag FIFO.
  - Set rr_ptr = (grant+1) mod NUM_REQ.
  - With no fire, rr_ptr holds; a stalled grant keeps priority, so operands stay stable while valid.
- Return path:
  - head = tag at rd_ptr; empty = (count==0).
  - res_valid[head] = unit_result_valid & ~empty; all other res_valid = 0.
  - unit_result_ready = ~empty & res_ready[head].
  - Return fire = unit_result_valid & unit_result_ready; pops the FIFO.
- FIFO:
  - Circular, wr_ptr/rd_ptr wrap at MAX_OUTSTANDING (not power of two).
  - Simultaneous push and pop: count unchanged; pointers both advance.
  - Full (count==MAX_OUTSTANDING): no push, even if a pop occurs the same cycle.
  - Empty with unit_result_valid=1 is a protocol violation: no res_valid, unit_result_ready=0, result held.
- Ordering:
  - Divider is in-order, so results return in issue order.
  - A stalled head requester (res_ready=0) back-pressures the divider and blocks results for all requesters.
- Latency added by this block: 0 cycles on both issue and return paths (purely combinational muxing plus registered pointers/FIFO).
- Throughput: one issue and one return per cycle.

Test Plan:
- Single requester: req_valid=01, lhs=0x40C00000 (6.0), rhs=0x40000000 (2.0) -> issue in cycle 0; later res_valid=01 with res_data[31:0]=0x40400000 (3.0); FIFO count returns to 0.
- Fairness: both requesters held valid continuously, unit_ready=1 -> grants alternate 0,1,0,1…; results return alternately to res_valid bits 0 and 1 in issue order.
- Outstanding limit: MAX_OUTSTANDING=4, res_ready=00 holding the divider output stalled -> after 4 issues req_ready stays 0 and unit_valid=0; raise res_ready=11 -> drains, then issue resumes.
- Head blocking: results tagged 1 then 0, res_ready=01 -> res_valid=10 shown, unit_result_ready=0, requester 0's result does not bypass; set res_ready[1]=1 -> both delivered in order.
- Wrap and simultaneous push/pop: MAX_OUTSTANDING=3, 10 back-to-back ops with res_ready=11 -> count stays constant in steady state, pointers wrap at 3, every result routed to its issuer.
- Reset mid-operation: assert rst with 3 ops in flight -> all valids/readies 0 asynchronously; after release count=0, rr_ptr=0, no stale results delivered.

Source files
------------

// File: rtl/divf_share_arbiter.sv
// Shares one in-order pipelined divider among NUM_REQ requesters: round-robin issue,
// requester tags kept in a circular FIFO so each returning result goes back to its issuer.
module divf_share_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_REQ         = 2,
    parameter int ID_WIDTH        = 1,
    parameter int MAX_OUTSTANDING = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_lhs,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_rhs,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ*DATA_WIDTH-1:0] res_data,
    output logic [NUM_REQ-1:0]            res_valid,
    input  logic [NUM_REQ-1:0]            res_ready,
    output logic [DATA_WIDTH-1:0]         unit_lhs,
    output logic [DATA_WIDTH-1:0]         unit_rhs,
    output logic                          unit_valid,
    input  logic                          unit_ready,
    input  logic [DATA_WIDTH-1:0]         unit_result,
    input  logic                          unit_result_valid,
    output logic                          unit_result_ready
);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ID_WIDTH-1:0] tag_q [MAX_OUTSTANDING];
    logic [ID_WIDTH-1:0] tag_d [MAX_OUTSTANDING];

    logic [ID_WIDTH-1:0] grant, head;
    logic                any_valid, can_issue, empty, head_ready;
    logic                issue_fire, ret_fire;

    // Search downward so the lowest offset from rr_ptr is the last (winning) assignment.
    always_comb begin
        int idx;
        grant     = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid[idx]) begin
                grant     = ID_WIDTH'(idx);
                any_valid = 1'b1;
            end
        end
    end

    assign can_issue  = (count_q < CNT_W'(MAX_OUTSTANDING));
    assign unit_valid = ~rst & any_valid & can_issue;
    assign unit_lhs   = req_lhs[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    assign unit_rhs   = req_rhs[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    assign issue_fire = unit_valid & unit_ready;

    assign head  = tag_q[rd_ptr_q];
    assign empty = (count_q == '0);

    always_comb begin
        req_ready  = '0;
        res_valid  = '0;
        head_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = ~rst & (grant == ID_WIDTH'(i)) & can_issue & unit_ready;
            res_valid[i] = ~rst & (head == ID_WIDTH'(i)) & unit_result_valid & ~empty;
            if (head == ID_WIDTH'(i)) head_ready = res_ready[i];
        end
    end

    assign unit_result_ready = ~rst & ~empty & head_ready;
    assign ret_fire          = unit_result_valid & unit_result_ready;
    assign res_data          = {NUM_REQ{unit_result}};

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        tag_d    = tag_q;
        if (issue_fire) begin
            tag_d[wr_ptr_q] = grant;
            wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
            rr_ptr_d = (grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        end
        if (ret_fire)
            rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
        case ({issue_fire, ret_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) tag_q[i] <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            tag_q    <= tag_d;
        end
    end
endmodule

// File: tb/tb_divf_share_arbiter.sv
// Randomized bench: a behavioural divider stub plus an in-order expectation queue
// that a negedge monitor compares against every handshake the arbiter presents.
module tb_divf_share_arbiter;
    localparam int DW = 32, N = 3, IDW = 2, MO = 3, LAT = 8, DCAP = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] req_lhs, req_rhs, res_data;
    logic [N-1:0]    req_valid, req_ready, res_valid, res_ready;
    logic [DW-1:0]   unit_lhs, unit_rhs, unit_result;
    logic            unit_valid, unit_ready, unit_result_valid, unit_result_ready;

    divf_share_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .ID_WIDTH(IDW), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .rst(rst),
        .req_lhs(req_lhs), .req_rhs(req_rhs), .req_valid(req_valid), .req_ready(req_ready),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .unit_lhs(unit_lhs), .unit_rhs(unit_rhs), .unit_valid(unit_valid), .unit_ready(unit_ready),
        .unit_result(unit_result), .unit_result_valid(unit_result_valid),
        .unit_result_ready(unit_result_ready)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int vpct = 0, rpct = 100, stall_pct = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    function automatic real sp2r(input logic [31:0] b);
        real r;
        r = 1.0 + real'(b[22:0]) / 8388608.0;
        for (int e = int'(b[30:23]); e > 127; e--) r = r * 2.0;
        for (int e = int'(b[30:23]); e < 127; e++) r = r / 2.0;
        return b[31] ? -r : r;
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
        return r2sp(sp2r(a) / sp2r(b));
    endfunction

    function automatic logic [31:0] rnd_f();
        return {1'($urandom_range(1)), 8'($urandom_range(140, 110)), 23'($urandom)};
    endfunction

    // Divider stub: elastic, in-order, LAT cycles, DCAP entries, cleared by rst.
    typedef struct {logic [31:0] d; int due;} dv_t;
    dv_t dq[$];
    int  cyc = 0;
    initial begin
        logic psh, pp;
        logic [31:0] a, b;
        unit_ready = 1'b0; unit_result_valid = 1'b0; unit_result = '0;
        forever begin
            @(negedge clk);
            psh = unit_valid & unit_ready;
            pp  = unit_result_valid & unit_result_ready;
            a = unit_lhs; b = unit_rhs;
            @(posedge clk); #1;
            cyc++;
            if (rst) dq.delete();
            else begin
                if (pp) void'(dq.pop_front());
                if (psh) dq.push_back('{fdiv(a, b), cyc + LAT - 1});
            end
            unit_ready        = !rst && dq.size() < DCAP && ($urandom_range(99) >= stall_pct);
            unit_result_valid = !rst && dq.size() > 0 && dq[0].due <= cyc;
            unit_result       = (dq.size() > 0) ? dq[0].d : 32'h0;
        end
    end

    // Expected results, in issue order, each tagged with the issuing requester.
    typedef struct {int id; logic [31:0] d;} ex_t;
    ex_t exq[$];
    int  ref_rr = 0;

    always @(negedge clk) begin : mon
        int g, h;
        logic anyv, can;
        logic [N-1:0] exp_rdy, exp_rv;
        logic exp_urr;
        if (rst) begin
            exq.delete();
            ref_rr = 0;
        end else begin
            anyv = |req_valid;
            g = 0;
            for (int k = N - 1; k >= 0; k--) if (req_valid[(ref_rr + k) % N]) g = (ref_rr + k) % N;
            can = exq.size() < MO;
            exp_rdy = '0;
            if (can && unit_ready) exp_rdy[g] = 1'b1;
            chk("unit_valid", unit_valid, anyv && can);
            chk("req_ready", req_ready, exp_rdy);

            exp_rv = '0; exp_urr = 1'b0; h = 0;
            if (exq.size() > 0) begin
                h = exq[0].id;
                exp_urr = res_ready[h];
                if (unit_result_valid) exp_rv[h] = 1'b1;
            end
            chk("res_valid", res_valid, exp_rv);
            chk("unit_result_ready", unit_result_ready, exp_urr);

            for (int i = 0; i < N; i++) begin
                if (res_valid[i] && res_ready[i]) begin
                    if (exq.size() == 0) chk("stale_result", 1, 0);
                    else begin
                        chk("res_id", i, exq[0].id);
                        chk("res_data", res_data[i*DW +: DW], exq[0].d);
                        void'(exq.pop_front());
                    end
                end
            end

            if (unit_valid && unit_ready && anyv && can) begin
                chk("unit_lhs", unit_lhs, req_lhs[g*DW +: DW]);
                exq.push_back('{g, fdiv(req_lhs[g*DW +: DW], req_rhs[g*DW +: DW])});
                ref_rr = (g + 1) % N;
            end
        end
    end

    task automatic run(input int n);
        logic [N-1:0] fired;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            fired = req_valid & req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || fired[i]) begin
                    req_valid[i] = ($urandom_range(99) < vpct);
                    req_lhs[i*DW +: DW] = rnd_f();
                    req_rhs[i*DW +: DW] = rnd_f();
                end
                res_ready[i] = ($urandom_range(99) < rpct);
            end
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req_ready"}, req_ready, '0);
        chk({tag, "_res_valid"}, res_valid, '0);
        chk({tag, "_unit_valid"}, unit_valid, 1'b0);
        chk({tag, "_unit_result_ready"}, unit_result_ready, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        rst = 1'b1;
        req_valid = '1; res_ready = '1;
        req_lhs = '0; req_rhs = '0;
        #2;
        chk_reset_outs("reset");
        req_valid = '0;
        @(posedge clk); #2;
        rst = 1'b0;

        // Single requester, 6.0 / 2.0
        @(posedge clk); #1;
        req_lhs[DW-1:0] = 32'h40C00000;
        req_rhs[DW-1:0] = 32'h40000000;
        req_valid = 3'b001;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (req_valid[0] && req_ready[0]) got = 1'b1;
        end
        if (!got) chk("single_issue_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid = '0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (res_valid[0]) begin
                got = 1'b1;
                chk("single_result", res_data[DW-1:0], 32'h40400000);
            end
        end
        if (!got) chk("single_return_timeout", 0, 1);

        // Fairness: everyone valid, no back-pressure
        vpct = 100; rpct = 100; stall_pct = 0;
        run(40);
        // Outstanding limit: results stalled, then drained
        rpct = 0;
        run(30);
        rpct = 100;
        run(20);
        // Head blocking and random traffic
        rpct = 50;
        run(100);
        vpct = 60; rpct = 70; stall_pct = 30;
        run(300);

        // Reset mid-operation with ops in flight
        vpct = 100; rpct = 0; stall_pct = 0;
        run(6);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk_reset_outs("midreset");
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b0;
        vpct = 60; rpct = 70; stall_pct = 20;
        run(100);

        // Drain
        vpct = 0; rpct = 100; stall_pct = 0;
        run(80);
        chk("drain_empty", exq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
